// File: rtl/cdb_result_buffer_if.sv
// FU/CDB-arbiter handshake bundle for one result buffer.
// slave = buffer side, master = FU + arbiter side.
interface cdb_result_buffer_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              cdb_req_valid;
  logic [TAG_W-1:0]  cdb_req_tag;
  logic [DATA_W-1:0] cdb_req_data;
  logic              cdb_grant;

  modport master (
    output in_valid,
    output in_tag,
    output in_data,
    output cdb_grant,
    input  in_ready,
    input  cdb_req_valid,
    input  cdb_req_tag,
    input  cdb_req_data
  );

  modport slave (
    input  in_valid,
    input  in_tag,
    input  in_data,
    input  cdb_grant,
    output in_ready,
    output cdb_req_valid,
    output cdb_req_tag,
    output cdb_req_data
  );
endinterface

// File: rtl/cdb_result_buffer.sv
// Per-FU result queue presenting its oldest entry to the CDB arbiter.
// Entries retire only on a registered grant for last cycle's request.
module cdb_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy,
  cdb_result_buffer_if.slave bus
);

  logic [TAG_W-1:0]  tags  [DEPTH];
  logic [DATA_W-1:0] datas [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             req_pending;

  logic             pop;
  logic             push;
  logic             req_valid;
  logic [PTR_W-1:0] eff_head;
  logic [CNT_W-1:0] eff_count;

  // Grants without a pending request are stale and must not pop.
  assign pop       = req_pending & bus.cdb_grant;
  assign eff_head  = head + PTR_W'(pop);
  assign eff_count = count - CNT_W'(pop);
  assign req_valid = (eff_count != '0) & ~flush;

  // Full is judged on registered count only, keeping grant off this path.
  assign bus.in_ready = (count != CNT_W'(DEPTH));
  assign push = bus.in_valid & bus.in_ready & ~flush;

  assign bus.cdb_req_valid = req_valid;
  assign bus.cdb_req_tag   = req_valid ? tags[eff_head]  : '0;
  assign bus.cdb_req_data  = req_valid ? datas[eff_head] : '0;
  assign occupancy         = count;

  always_ff @(posedge clock) begin
    if (push) begin
      tags[tail]  <= bus.in_tag;
      datas[tail] <= bus.in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      req_pending <= 1'b0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      req_pending <= 1'b0;
    end else begin
      head        <= eff_head;
      tail        <= tail + PTR_W'(push);
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      req_pending <= req_valid;
    end
  end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Directed bench for cdb_result_buffer: vector table plus reset sequence.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_cdb_result_buffer;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] occ;

  cdb_result_buffer_if #(.TAG_W(6), .DATA_W(32)) bus ();

  cdb_result_buffer #(
    .DEPTH(4), .TAG_W(6), .DATA_W(32)
  ) dut (
    .clock(clk),
    .reset(rst),
    .flush(flush),
    .occupancy(occ),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [5:0] it;
    logic       g;
    logic       f;
    logic       ev;
    logic [5:0] et;
    logic       er;
    logic [2:0] eo;
  } vec_t;

  vec_t vecs[$];
  int   tests;
  int   fails;

  function automatic logic [31:0] dat(input logic [5:0] t);
    dat = (t == 6'd5) ? 32'h1234 : 32'h1000 + 32'(t);
  endfunction

  function automatic vec_t mk(
    input logic iv, input int it, input logic g,
    input logic f, input logic ev, input int et,
    input logic er, input int eo);
    vec_t v;
    v.iv = iv; v.it = 6'(it); v.g = g; v.f = f;
    v.ev = ev; v.et = 6'(et); v.er = er; v.eo = 3'(eo);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [5:0] t,
                       input logic g, input logic f);
    bus.in_valid  = iv;
    bus.in_tag    = t;
    bus.in_data   = iv ? dat(t) : 32'h0;
    bus.cdb_grant = g;
    flush         = f;
  endtask

  task automatic chk_out(input string nm, input logic ev,
                         input logic [5:0] et,
                         input logic er, input logic [2:0] eo);
    chk({nm, ".valid"}, 0, 32'(bus.cdb_req_valid), 32'(ev));
    chk({nm, ".tag"}, 0, 32'(bus.cdb_req_tag),
        ev ? 32'(et) : 32'h0);
    chk({nm, ".data"}, 0, bus.cdb_req_data,
        ev ? dat(et) : 32'h0);
    chk({nm, ".ready"}, 0, 32'(bus.in_ready), 32'(er));
    chk({nm, ".occ"}, 0, 32'(occ), 32'(eo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    // single result
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    // starvation
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4, 0, 0, 1, 3, 1, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 2));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4, 1, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    // fill, full drop, drain, wrap
    vecs.push_back(mk(1, 10, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 11, 0, 0, 1, 10, 1, 1));
    vecs.push_back(mk(1, 12, 0, 0, 1, 10, 1, 2));
    vecs.push_back(mk(1, 13, 0, 0, 1, 10, 1, 3));
    vecs.push_back(mk(1, 14, 0, 0, 1, 10, 0, 4));
    vecs.push_back(mk(0, 0, 1, 0, 1, 11, 0, 4));
    vecs.push_back(mk(0, 0, 1, 0, 1, 12, 1, 3));
    vecs.push_back(mk(0, 0, 1, 0, 1, 13, 1, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 14, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 15, 0, 0, 1, 14, 1, 1));
    // simultaneous push and pop at occupancy 2
    vecs.push_back(mk(1, 16, 1, 0, 1, 15, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 15, 1, 2));
    // flush with 3 entries, stale grant after
    vecs.push_back(mk(1, 17, 0, 0, 1, 15, 1, 2));
    vecs.push_back(mk(1, 20, 0, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));

    drive(0, 6'd0, 0, 0);
    rst = 1'b1;
    #1;
    chk_out("reset", 0, 6'd0, 1, 3'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].iv, vecs[i].it, vecs[i].g, vecs[i].f);
      @(negedge clk);
      chk("valid", i, 32'(bus.cdb_req_valid),
          32'(vecs[i].ev));
      chk("tag", i, 32'(bus.cdb_req_tag),
          vecs[i].ev ? 32'(vecs[i].et) : 32'h0);
      chk("data", i, bus.cdb_req_data,
          vecs[i].ev ? dat(vecs[i].et) : 32'h0);
      chk("ready", i, 32'(bus.in_ready), 32'(vecs[i].er));
      chk("occ", i, 32'(occ), 32'(vecs[i].eo));
    end

    // asynchronous reset mid-stream with 2 entries
    @(posedge clk); #1; drive(1, 6'd21, 0, 0);
    @(posedge clk); #1; drive(1, 6'd22, 0, 0);
    @(posedge clk); #1; drive(0, 6'd0, 0, 0);
    @(negedge clk);
    chk_out("pre_rst", 1, 6'd21, 1, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 6'd0, 1, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_out("post_rst", 0, 6'd0, 1, 3'd0);
    @(posedge clk); #1; drive(1, 6'd23, 0, 0);
    @(posedge clk); #1; drive(0, 6'd0, 0, 0);
    @(negedge clk);
    chk_out("rst_push", 1, 6'd23, 1, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
